// File: rtl/delay_measure_ctrl.sv
// Propagation-delay measurement sequencer: launches alternating edges into the chain and counts cycles until they return.
// Optional DELAY_SYNC_COMP_EN removes synchronizer latency from run-match captures.
module delay_measure_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             path_in,
    input  logic             path_out,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_e;

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] SYNC_CNT = CNT_W'(SYNC_STAGES);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       result_q;
    logic [CNT_W-1:0]       runResult_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pathIn_q;
    logic                   resultValid_q;
    logic                   timeout_q;
    logic                   busy_q;
    logic                   settled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], path_out};
        end
    end

    // The chain is non-inverting, so it has settled once the synchronized output equals the drive.
    assign settled = (sync_q[SYNC_STAGES-1] == pathIn_q);

    always_comb begin
`ifdef DELAY_SYNC_COMP_EN
        runResult_d = (cnt_q >= SYNC_CNT) ? (cnt_q - SYNC_CNT) : '0;
`else
        runResult_d = cnt_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            result_q      <= '0;
            pathIn_q      <= 1'b0;
            resultValid_q <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ARM;
                    end
                end
                ARM: begin
                    if (settled) begin
                        pathIn_q <= ~pathIn_q;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end else if (cnt_q == LIMIT) begin
                        result_q      <= cnt_q;
                        timeout_q     <= 1'b1;
                        resultValid_q <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // A match wins over the limit when both occur in the same cycle.
                RUN: begin
                    if (settled) begin
                        result_q      <= runResult_d;
                        resultValid_q <= 1'b1;
                        state_q       <= DONE;
                    end else if (cnt_q == LIMIT) begin
                        result_q      <= cnt_q;
                        timeout_q     <= 1'b1;
                        resultValid_q <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        resultValid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign path_in      = pathIn_q;
    assign result       = result_q;
    assign result_valid = resultValid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_delay_measure_ctrl.sv
// Self-checking bench for delay_measure_ctrl: a delay-line loopback model drives path_out and a
// scoreboard queue holds the expected capture for every launched measurement.
module tb_delay_measure_ctrl;

    localparam int SYNC   = 2;
    localparam int LIMIT  = 100;
    localparam int BUDGET = 300;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        pathIn;
    logic        pathOut;
    logic [31:0] result;
    logic        resultValid;
    logic        resultAck;
    logic        timeoutO;

    logic [15:0] dlyLine = '0;
    int          dlyD;
    logic        stuckEn;
    logic        stuckVal;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [31:0] res;
        logic        to;
        int          lat;
        int          toggles;
    } expT;

    expT sbQ[$];

    delay_measure_ctrl #(
        .SYNC_STAGES   (SYNC),
        .CNT_W         (32),
        .TIMEOUT_CYCLES(LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .path_in     (pathIn),
        .path_out    (pathOut),
        .result      (result),
        .result_valid(resultValid),
        .result_ack  (resultAck),
        .timeout     (timeoutO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: path_out is path_in delayed by dlyD register stages, or forced to a stuck level.
    always @(posedge clk) dlyLine <= {dlyLine[14:0], pathIn};

    always_comb begin
        pathOut = pathIn;
        if (stuckEn) pathOut = stuckVal;
        else if (dlyD > 0) pathOut = dlyLine[dlyD-1];
    end

    // Capture value expected for a loopback of d register stages.
    function automatic logic [31:0] expMeas(input int d);
`ifdef DELAY_SYNC_COMP_EN
        return (d + SYNC >= SYNC) ? 32'(d) : 32'd0;
`else
        return 32'(d + SYNC);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Launch one measurement, optionally keeping start high for extra cycles, then score the capture.
    task automatic applyStimulus(input logic [31:0] expRes, input logic expTo, input int expLat,
                                 input int expToggles, input int extraStart);
        expT  e;
        int   launchCyc;
        int   validCyc;
        int   toggles;
        int   cyc;
        logic prevPin;
        e.res = expRes;
        e.to = expTo;
        e.lat = expLat;
        e.toggles = expToggles;
        sbQ.push_back(e);
        @(negedge clk);
        prevPin = pathIn;
        start = 1'b1;
        launchCyc = -1;
        validCyc = -1;
        toggles = 0;
        cyc = 0;
        while (validCyc < 0 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc > extraStart) start = 1'b0;
            if (pathIn !== prevPin) begin
                toggles++;
                if (launchCyc < 0) launchCyc = cyc;
            end
            prevPin = pathIn;
            if (resultValid) validCyc = cyc;
        end
        start = 1'b0;
        e = sbQ.pop_front();
        if (validCyc < 0) begin
            checkOutput("valid_wait", 32'd0, 32'd1);
        end else begin
            checkOutput("result", result, e.res);
            checkOutput("timeout", 32'(timeoutO), 32'(e.to));
            checkOutput("launch_toggles", 32'(toggles), 32'(e.toggles));
            if (e.lat >= 0) checkOutput("valid_latency", 32'(validCyc - launchCyc), 32'(e.lat));
        end
    endtask

    // Hold off the ack, then acknowledge (optionally with start high alongside).
    task automatic ackResult(input logic [31:0] expRes, input int hold, input logic startWithAck);
        logic pinBefore;
        repeat (hold) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(resultValid), 32'd1);
            checkOutput("hold_result", result, expRes);
        end
        pinBefore = pathIn;
        resultAck = 1'b1;
        start = startWithAck;
        @(negedge clk);
        resultAck = 1'b0;
        start = 1'b0;
        checkOutput("ack_valid_low", 32'(resultValid), 32'd0);
        checkOutput("ack_busy_low", 32'(busy), 32'd0);
        if (startWithAck) begin
            repeat (4) begin
                @(negedge clk);
                checkOutput("no_restart_busy", 32'(busy), 32'd0);
            end
            checkOutput("no_restart_pin", 32'(pathIn), 32'(pinBefore));
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Abort a measurement a few cycles into RUN and confirm outputs drop to reset values at once.
    task automatic midRunReset();
        int cyc;
        logic prevPin;
        @(negedge clk);
        prevPin = pathIn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (pathIn === prevPin && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (pathIn === prevPin) checkOutput("mr_launch", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mr_busy", 32'(busy), 32'd0);
        checkOutput("mr_path_in", 32'(pathIn), 32'd0);
        checkOutput("mr_result", result, 32'd0);
        checkOutput("mr_valid", 32'(resultValid), 32'd0);
        checkOutput("mr_timeout", 32'(timeoutO), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        resultAck = 1'b0;
        stuckEn = 1'b0;
        stuckVal = 1'b0;
        dlyD = 5;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_path_in", 32'(pathIn), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_valid", 32'(resultValid), 32'd0);
        checkOutput("rst_timeout", 32'(timeoutO), 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] registered loopback D=5, rising launch");
        applyStimulus(expMeas(5), 1'b0, 5 + SYNC + 1, 1, 0);
        checkOutput("launch_rise", 32'(pathIn), 32'd1);
        ackResult(expMeas(5), 10, 1'b0);
        repeat (8) @(negedge clk);

        $display("[TB] falling launch, start alongside ack");
        applyStimulus(expMeas(5), 1'b0, 5 + SYNC + 1, 1, 0);
        checkOutput("launch_fall", 32'(pathIn), 32'd0);
        ackResult(expMeas(5), 0, 1'b1);
        repeat (8) @(negedge clk);

        $display("[TB] start held through ARM and RUN");
        applyStimulus(expMeas(5), 1'b0, 5 + SYNC + 1, 1, 5);
        ackResult(expMeas(5), 0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("single_result_busy", 32'(busy), 32'd0);

        $display("[TB] combinational loopback");
        dlyD = 0;
        repeat (4) @(negedge clk);
        applyStimulus(expMeas(0), 1'b0, SYNC + 1, 1, 0);
        ackResult(expMeas(0), 0, 1'b0);

        $display("[TB] stuck output, RUN limit");
        stuckEn = 1'b1;
        stuckVal = 1'b0;
        doReset();
        applyStimulus(32'(LIMIT), 1'b1, -1, 1, 0);
        ackResult(32'(LIMIT), 5, 1'b0);

        $display("[TB] stuck output, ARM limit");
        stuckVal = 1'b1;
        doReset();
        applyStimulus(32'(LIMIT), 1'b1, -1, 0, 0);
        checkOutput("arm_to_path_in", 32'(pathIn), 32'd0);
        ackResult(32'(LIMIT), 2, 1'b0);

        $display("[TB] reset during RUN");
        stuckEn = 1'b0;
        dlyD = 5;
        repeat (8) @(negedge clk);
        midRunReset();
        applyStimulus(expMeas(5), 1'b0, 5 + SYNC + 1, 1, 0);
        ackResult(expMeas(5), 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
